ntt_out_collector: RTL and testbench
====================================

NTT_OUT_COLLECTOR -- requirements
Module: ntt_out_collector

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the input word width, with coefficient in bits [COEF_W-1:0].
REQ-002 SHALL have parameter COEF_W, default 16, meaning the coefficient and modulus width.
REQ-003 SHALL have parameter MAX_DEPTH, default 10, meaning log2 of the largest ring (1024).
REQ-004 SHALL have parameter CH, default 1, legal values 1 and 2, meaning input words per beat.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 start  in  1  one-cycle pulse that begins a capture and latches q and ring_depth.
REQ-009 q  in  COEF_W  modulus.
REQ-010 ring_depth  in  4  log2 N, legal range 2..MAX_DEPTH.
REQ-011 in_valid  in  1  input beat valid.
REQ-012 in_ready  out  1  high only in CAPTURE.
REQ-013 in_data  in  CH*DATA_W  CH consecutive NTT output words, lane 0 first.
REQ-014 out_valid  out  1  drained coefficient valid.
REQ-015 out_ready  in  1  downstream accept.
REQ-016 out_data  out  COEF_W  reduced coefficient, natural order.
REQ-017 out_idx  out  MAX_DEPTH  natural index of out_data.
REQ-018 busy  out  1  high when not IDLE.
REQ-019 done  out  1  one-cycle pulse after the last drain beat is accepted.

Function
REQ-020 SHALL have FSM states IDLE, CAPTURE, DRAIN; IDLE->CAPTURE on start; CAPTURE->DRAIN when word count m reaches N; DRAIN->IDLE when the index-N-1 beat is accepted.
REQ-021 SHALL ignore start outside IDLE.
REQ-022 SHALL accept a beat when in_valid && in_ready; lanes 0..CH-1 carry word numbers m..m+CH-1.
REQ-023 SHALL write word m to index (m>>1) + (m[0] ? N/2 : 0), with N = 1<<ring_depth.
REQ-024 SHALL use two banks, lower half (indices < N/2) and upper half, so a CH=2 beat writes one word to each bank in the same cycle.
REQ-025 SHALL reduce each coefficient before the write: c >= q gives c-q, else c, using latched q.
REQ-026 SHALL drain indices 0..N-1 in ascending order, one per accepted beat; out_data and out_idx SHALL hold stable while out_valid && !out_ready.
REQ-027 SHALL raise first out_valid 2 cycles after the final capture beat (1 cycle state change + 1 cycle synchronous RAM read).
REQ-028 SHALL assert done exactly one cycle after the final drain handshake, concurrent with the return to IDLE.
REQ-029 SHALL accept start in the same cycle done is high only if the FSM is already in IDLE; otherwise start is ignored.
REQ-030 SHALL treat ring_depth outside 2..MAX_DEPTH as MAX_DEPTH.

Reset
REQ-031 SHALL, on reset (including mid-CAPTURE or mid-DRAIN), go to IDLE and clear counters.
REQ-032 SHALL reset in_ready, out_valid, busy, done to 0 and out_data, out_idx to 0.
REQ-033 SHALL NOT clear bank contents on reset.

Configuration
REQ-034 SHALL compile in the overflow monitor when NTT_OUT_OVF_EN is defined: an extra output port ovf (1 bit) is set sticky when an accepted coefficient is >= 2q, and is cleared by reset or start.
REQ-035 SHALL, without NTT_OUT_OVF_EN, have no ovf port and no monitor logic.

Structure
REQ-036 SHALL define the FSM state encoding and the bank address-mapping function in shared package ntt_pkg.
REQ-037 SHALL use one sub-module ntt_coef_bank (single-port write, synchronous read), instantiated twice.

Verification
REQ-038 Test: q=3329, depth 8, CH=1, input m=0..255 with value m -> out index k=m>>1 (m even) or k-128=m>>1 (m odd), 256 beats, done once.
REQ-039 Test: input 3329 and 3400 with q=3329 -> outputs 0 and 71.
REQ-040 Test: CH=2, depth 10, 512 beats -> 1024 natural-order outputs, first out_valid exactly 2 cycles after the last in-handshake.
REQ-041 Test: out_ready toggled 1/0 randomly during drain -> no lost or duplicated out_idx, data stable while stalled.
REQ-042 Test: reset asserted at m=100 -> next cycle IDLE, all outputs 0; a fresh start captures correctly.
REQ-043 Test: with NTT_OUT_OVF_EN, input 6658 with q=3329 -> ovf=1 until the next start.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared types for the NTT output collector: FSM encoding and the
// bit-reversed-pair to natural-order index mapping.
package ntt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } ntt_state_e;

    localparam int unsigned NTT_IDX_W = 16;

    // Word m lands at (m>>1), odd words shifted into the upper half.
    function automatic logic [NTT_IDX_W-1:0] ntt_map_idx(
        input logic [NTT_IDX_W-1:0] m,
        input logic [3:0]           depth
    );
        logic [NTT_IDX_W-1:0] half;
        half = NTT_IDX_W'(1) << (depth - 4'd1);
        return (m >> 1) + (m[0] ? half : '0);
    endfunction

endpackage

// File: rtl/ntt_coef_bank.sv
// One half-ring coefficient store: single write port, registered read.
// Contents are deliberately not reset.
module ntt_coef_bank #(
    parameter int W  = 16,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [2**AW];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/ntt_out_collector.sv
// Captures NTT output words, reduces mod q, drains them in natural order.
// Define NTT_OUT_OVF_EN to add the sticky ovf (coefficient >= 2q) port.
module ntt_out_collector
    import ntt_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int COEF_W    = 16,
    parameter int MAX_DEPTH = 10,
    parameter int CH        = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [COEF_W-1:0]    q,
    input  logic [3:0]           ring_depth,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CH*DATA_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [COEF_W-1:0]    out_data,
    output logic [MAX_DEPTH-1:0] out_idx,
    output logic                 busy,
    output logic                 done
`ifdef NTT_OUT_OVF_EN
    ,
    output logic                 ovf
`endif
);

    localparam int CW = MAX_DEPTH + 1;
    localparam int AW = MAX_DEPTH - 1;
    localparam logic [3:0] DMAX = 4'(MAX_DEPTH);

    ntt_state_e r_state, w_state_nxt;

    logic [COEF_W-1:0]    r_q;
    logic [3:0]           r_depth;
    logic [CW-1:0]        r_m;
    logic [CW-1:0]        r_rd;
    logic                 r_out_valid;
    logic                 r_rd_hi;
    logic [MAX_DEPTH-1:0] r_out_idx;
    logic                 r_done;

    logic [3:0]    w_depth_in;
    logic [CW-1:0] w_n, w_half, w_m_nxt;
    logic          w_start, w_acc, w_fire, w_last, w_rd_en, w_rd_hi;
    logic [AW-1:0] w_raddr;

    assign w_depth_in = (ring_depth < 4'd2 || ring_depth > DMAX)
                      ? DMAX : ring_depth;
    assign w_n     = CW'(1) << r_depth;
    assign w_half  = w_n >> 1;
    assign w_start = start && (r_state == ST_IDLE);
    assign w_acc   = in_valid && (r_state == ST_CAPTURE);
    assign w_m_nxt = r_m + CW'(CH);
    assign w_fire  = r_out_valid && out_ready;
    assign w_last  = w_fire && ({1'b0, r_out_idx} == w_n - CW'(1));
    // Refill the output register whenever it is empty or being consumed.
    assign w_rd_en = (r_state == ST_DRAIN) && (r_rd < w_n)
                   && (!r_out_valid || w_fire);
    assign w_rd_hi = r_rd >= w_half;
    assign w_raddr = w_rd_hi ? AW'(r_rd - w_half) : AW'(r_rd);

    logic [CH-1:0]     w_lhi;
    logic [AW-1:0]     w_laddr [CH];
    logic [COEF_W-1:0] w_lcoef [CH];
`ifdef NTT_OUT_OVF_EN
    logic [CH-1:0]     w_lovf;
`endif

    for (genvar l = 0; l < CH; l++) begin : g_lane
        logic [COEF_W-1:0]    w_c;
        logic [NTT_IDX_W-1:0] w_idx;
        logic [CW-1:0]        w_k;
        logic                 w_unused;
        assign w_c   = in_data[l*DATA_W +: COEF_W];
        assign w_idx = ntt_map_idx(NTT_IDX_W'(r_m + CW'(l)), r_depth);
        assign w_k   = w_idx[CW-1:0];
        assign w_lhi[l]   = w_k >= w_half;
        assign w_laddr[l] = w_lhi[l] ? AW'(w_k - w_half) : AW'(w_k);
        assign w_lcoef[l] = (w_c >= r_q) ? w_c - r_q : w_c;
        assign w_unused   = ^{w_idx, in_data[l*DATA_W +: DATA_W]};
`ifdef NTT_OUT_OVF_EN
        assign w_lovf[l]  = {1'b0, w_c} >= {r_q, 1'b0};
`endif
    end

    logic [1:0]        w_we;
    logic [AW-1:0]     w_waddr [2];
    logic [COEF_W-1:0] w_wdata [2];
    logic [COEF_W-1:0] w_rdata [2];

    always_comb begin
        w_we    = '0;
        w_waddr = '{default: '0};
        w_wdata = '{default: '0};
        for (int l = 0; l < CH; l++) begin
            if (w_acc) begin
                w_we[w_lhi[l]]    = 1'b1;
                w_waddr[w_lhi[l]] = w_laddr[l];
                w_wdata[w_lhi[l]] = w_lcoef[l];
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        ntt_coef_bank #(.W(COEF_W), .AW(AW)) u_bank (
            .clk     (clk),
            .i_we    (w_we[b]),
            .i_waddr (w_waddr[b]),
            .i_wdata (w_wdata[b]),
            .i_re    (w_rd_en && (w_rd_hi == (b != 0))),
            .i_raddr (w_raddr),
            .o_rdata (w_rdata[b])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:    if (w_start) w_state_nxt = ST_CAPTURE;
            ST_CAPTURE: if (w_acc && w_m_nxt >= w_n) w_state_nxt = ST_DRAIN;
            ST_DRAIN:   if (w_last) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q         <= '0;
            r_depth     <= DMAX;
            r_m         <= '0;
            r_rd        <= '0;
            r_out_valid <= 1'b0;
            r_rd_hi     <= 1'b0;
            r_out_idx   <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_start) begin
                r_q     <= q;
                r_depth <= w_depth_in;
                r_m     <= '0;
                r_rd    <= '0;
            end
            if (w_acc) r_m <= w_m_nxt;
            if (w_rd_en) begin
                r_out_valid <= 1'b1;
                r_out_idx   <= r_rd[MAX_DEPTH-1:0];
                r_rd_hi     <= w_rd_hi;
                r_rd        <= r_rd + CW'(1);
            end else if (w_fire) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef NTT_OUT_OVF_EN
    logic r_ovf;
    always_ff @(posedge clk) begin
        if (reset || w_start)       r_ovf <= 1'b0;
        else if (w_acc && |w_lovf)  r_ovf <= 1'b1;
    end
    assign ovf = r_ovf;
`endif

    assign in_ready  = (r_state == ST_CAPTURE);
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign out_valid = r_out_valid;
    assign out_idx   = r_out_idx;
    assign out_data  = r_out_valid ? w_rdata[r_rd_hi] : '0;

endmodule

// File: tb/tb_ntt_out_collector.sv
// Directed-random bench: CH=1 and CH=2 collectors against a natural-order
// reference built from the index/reduction rules.
module tb_ntt_out_collector;

    localparam int DW = 32;
    localparam int CW = 16;
    localparam int MD = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic        reset, start, in_valid, out_ready, sel;
    logic [15:0] q;
    logic [3:0]  ring_depth;
    logic [63:0] in_data;

    logic ir1, ov1, b1, d1, ir2, ov2, b2, d2;
    logic [15:0] od1, od2;
    logic [9:0]  oi1, oi2;
`ifdef NTT_OUT_OVF_EN
    logic ovf1, ovf2;
`endif

    ntt_out_collector #(.DATA_W(DW), .COEF_W(CW), .MAX_DEPTH(MD), .CH(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start && !sel), .q(q),
        .ring_depth(ring_depth), .in_valid(in_valid && !sel), .in_ready(ir1),
        .in_data(in_data[31:0]), .out_valid(ov1), .out_ready(out_ready && !sel),
        .out_data(od1), .out_idx(oi1), .busy(b1), .done(d1)
`ifdef NTT_OUT_OVF_EN
        , .ovf(ovf1)
`endif
    );

    ntt_out_collector #(.DATA_W(DW), .COEF_W(CW), .MAX_DEPTH(MD), .CH(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start && sel), .q(q),
        .ring_depth(ring_depth), .in_valid(in_valid && sel), .in_ready(ir2),
        .in_data(in_data), .out_valid(ov2), .out_ready(out_ready && sel),
        .out_data(od2), .out_idx(oi2), .busy(b2), .done(d2)
`ifdef NTT_OUT_OVF_EN
        , .ovf(ovf2)
`endif
    );

    wire        w_ir   = sel ? ir2 : ir1;
    wire        w_ov   = sel ? ov2 : ov1;
    wire        w_busy = sel ? b2  : b1;
    wire        w_done = sel ? d2  : d1;
    wire [15:0] w_od   = sel ? od2 : od1;
    wire [9:0]  w_oi   = sel ? oi2 : oi1;

    int n_chk = 0;
    int n_err = 0;

    int unsigned wv [1024];
    int          expv [1024];
    int          cur_n, cur_ch;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Natural-order expectation: even words fill the lower half, odd the upper.
    function automatic void build_exp(input int d, input int qv);
        int n, v, k;
        n = 1 << d;
        for (int m = 0; m < n; m++) begin
            v = int'(wv[m] & 32'hFFFF);
            k = (m % 2 == 0) ? m / 2 : m / 2 + n / 2;
            expv[k] = (v >= qv) ? v - qv : v;
        end
    endfunction

    task automatic fill_rand();
        for (int m = 0; m < 1024; m++) wv[m] = $urandom;
    endtask

    task automatic start_run(input logic s, input int qv, input logic [3:0] d);
        int de;
        de = (d < 2 || d > MD) ? MD : int'(d);
        sel = s;
        cur_ch = s ? 2 : 1;
        cur_n = 1 << de;
        build_exp(de, qv);
        q = qv[15:0];
        ring_depth = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        q = 16'($urandom);
        ring_depth = 4'($urandom);
        chk("busy_after_start", w_busy, 1);
        chk("done_after_start", w_done, 0);
        chk("in_ready_capture", w_ir, 1);
    endtask

    task automatic capture(input int gap, input int abort_at, input bit poke,
                           output int hs_neg);
        int m, guard;
        m = 0;
        guard = 0;
        hs_neg = -100;
        while (m < cur_n && m < abort_at && guard < 5000) begin
            guard++;
            in_valid = ($urandom_range(99) >= gap);
            in_data = {wv[(m + 1) % 1024], wv[m]};
            if (poke && (guard % 5 == 2)) begin
                start = 1'b1;
                q = 16'd1;
            end else begin
                start = 1'b0;
            end
            if (in_valid && w_ir) begin
                m += cur_ch;
                hs_neg = cyc;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        start = 1'b0;
        if (abort_at > cur_n) chk("capture_count", m, cur_n);
    endtask

    task automatic drain(input int rp, input bit lat, input int hs_neg);
        int k, guard, dones;
        bit first, stalled;
        logic [15:0] sd;
        logic [9:0]  si;
        k = 0; guard = 0; dones = 0;
        first = 1'b1; stalled = 1'b0;
        sd = '0; si = '0;
        chk("in_ready_drain", w_ir, 0);
        while (k < cur_n && guard < 8000) begin
            guard++;
            dones += int'(w_done);
            if (w_ov) begin
                if (first && lat) chk("first_valid_lat", cyc - hs_neg, 2);
                first = 1'b0;
                if (stalled) begin
                    chk("stall_data", w_od, sd);
                    chk("stall_idx", w_oi, si);
                end
                chk("out_idx", w_oi, k);
                chk("out_data", w_od, expv[k]);
                out_ready = ($urandom_range(99) < rp);
                stalled = !out_ready;
                sd = w_od;
                si = w_oi;
                if (out_ready) k++;
            end else begin
                out_ready = ($urandom_range(99) < rp);
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("drain_count", k, cur_n);
        chk("done_during_drain", dones, 0);
        chk("done_pulse", w_done, 1);
        chk("busy_after_drain", w_busy, 0);
        chk("valid_after_drain", w_ov, 0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_in_ready"}, w_ir, 0);
        chk({tag, "_out_valid"}, w_ov, 0);
        chk({tag, "_busy"}, w_busy, 0);
        chk({tag, "_done"}, w_done, 0);
        chk({tag, "_out_data"}, w_od, 0);
        chk({tag, "_out_idx"}, w_oi, 0);
    endtask

    initial begin
        int hs;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        sel = 1'b0; q = '0; ring_depth = '0; in_data = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_idle("rst_ch1");
        sel = 1'b1;
        chk_idle("rst_ch2");

        // Ramp 0..255, depth 8, full-rate both sides
        for (int m = 0; m < 1024; m++) wv[m] = {16'($urandom), 16'(m)};
        start_run(1'b0, 3329, 4'd8);
        capture(0, 1 << 30, 1'b0, hs);
        drain(100, 1'b1, hs);

        // Start in the done cycle; reduction boundary values
        fill_rand();
        wv[0] = 32'd3329;
        wv[1] = 32'd3400;
        start_run(1'b0, 3329, 4'd2);
        capture(30, 1 << 30, 1'b0, hs);
        drain(100, 1'b1, hs);

        // Two lanes, largest ring
        fill_rand();
        start_run(1'b1, 12289, 4'd10);
        capture(0, 1 << 30, 1'b0, hs);
        drain(100, 1'b1, hs);

        // Gappy input, stray starts mid-capture, random backpressure
        fill_rand();
        start_run(1'b1, 3329, 4'd5);
        capture(40, 1 << 30, 1'b1, hs);
        drain(50, 1'b1, hs);

        // Reset mid-capture, then a clean run
        fill_rand();
        start_run(1'b0, 7681, 4'd9);
        capture(0, 100, 1'b0, hs);
        reset = 1'b1;
        @(negedge clk);
        chk_idle("mid_reset");
        reset = 1'b0;
        @(negedge clk);
        fill_rand();
        start_run(1'b0, 7681, 4'd7);
        capture(20, 1 << 30, 1'b0, hs);
        drain(70, 1'b1, hs);

        // Out-of-range depth falls back to the largest ring
        fill_rand();
        start_run(1'b1, 40961, 4'd0);
        capture(10, 1 << 30, 1'b0, hs);
        drain(90, 1'b1, hs);

`ifdef NTT_OUT_OVF_EN
        fill_rand();
        wv[0] = 32'd6658;
        wv[1] = 32'd1;
        wv[2] = 32'd2;
        wv[3] = 32'd3;
        start_run(1'b0, 3329, 4'd2);
        capture(0, 1 << 30, 1'b0, hs);
        drain(100, 1'b1, hs);
        chk("ovf_set", ovf1, 1);
        for (int m = 0; m < 4; m++) wv[m] = 32'(m + 10);
        start_run(1'b0, 3329, 4'd2);
        chk("ovf_cleared", ovf1, 0);
        capture(0, 1 << 30, 1'b0, hs);
        drain(100, 1'b1, hs);
        chk("ovf_stays_clear", ovf1, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
